// File: rtl/shift_pkg.sv
// Shared encodings for the shift issue/writeback controller.
// Holds shift ctrl codes, FSM states and the default watchdog limit.
package shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

endpackage

// File: rtl/shift_watchdog.sv
// Saturating 8-bit wait counter for the shift issue controller.
// first flags the opening wait cycle; expire flags the last allowed one.
module shift_watchdog
    import shift_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic first,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    // Count wait cycles, cleared on launch, never wrapping past 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign first  = (cnt == 8'd0);
    assign expire = (cnt >= LAST);

endmodule

// File: rtl/shift_issue_ctrl.sv
// Issue/writeback controller wrapping a sequential shifter.
// Optional SHIFT_ZERO_BYPASS_EN: zero-amount ops skip the shifter.
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int AMT_W   = 3,
    parameter int DEST_W  = 3,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_ctrl,
    input  logic [AMT_W-1:0]  req_amt,
    input  logic [WIDTH-1:0]  req_data,
    input  logic [DEST_W-1:0] req_dest,
    output logic              sh_start,
    output logic [1:0]        sh_ctrl,
    output logic [AMT_W-1:0]  sh_amt,
    output logic [WIDTH-1:0]  sh_data,
    input  logic [WIDTH-1:0]  sh_result,
    input  logic              sh_done,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [WIDTH-1:0]  wb_data,
    output logic [DEST_W-1:0] wb_dest,
    output logic              wb_err,
    output logic              busy
);

    state_t state;
    state_t state_nxt;
    logic   bypass;
    logic   wd_clr;
    logic   wd_en;
    logic   wd_first;
    logic   wd_expire;
    logic   done_ok;

`ifdef SHIFT_ZERO_BYPASS_EN
    assign bypass = (req_amt == '0);
`else
    assign bypass = 1'b0;
`endif

    assign wd_clr  = (state == ST_LAUNCH);
    assign wd_en   = (state == ST_WAIT);
    assign done_ok = sh_done && !wd_first;

    shift_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .first  (wd_first),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        sh_start  = 1'b0;
        wb_valid  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = bypass ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                sh_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_ok || wd_expire) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch on accept, result capture on done or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_ctrl <= '0;
            sh_amt  <= '0;
            sh_data <= '0;
            wb_dest <= '0;
            wb_data <= '0;
            wb_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                sh_ctrl <= req_ctrl;
                sh_amt  <= req_amt;
                sh_data <= req_data;
                wb_dest <= req_dest;
                if (bypass) begin
                    wb_data <= req_data;
                    wb_err  <= 1'b0;
                end
            end
            if (state == ST_WAIT) begin
                if (done_ok) begin
                    wb_data <= sh_result;
                    wb_err  <= 1'b0;
                end else if (wd_expire) begin
                    wb_data <= '0;
                    wb_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Self-checking bench for shift_issue_ctrl with a behavioural shifter stub.
// Directed table, hand sequences for reset, then randomized ops vs a model.
module tb_shift_issue_ctrl;

    localparam int WIDTH   = 8;
    localparam int AMT_W   = 3;
    localparam int DEST_W  = 3;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_ctrl;
    logic [AMT_W-1:0]  req_amt;
    logic [WIDTH-1:0]  req_data;
    logic [DEST_W-1:0] req_dest;
    logic              sh_start;
    logic [1:0]        sh_ctrl;
    logic [AMT_W-1:0]  sh_amt;
    logic [WIDTH-1:0]  sh_data;
    logic [WIDTH-1:0]  sh_result;
    logic              sh_done;
    logic              wb_valid;
    logic              wb_ready;
    logic [WIDTH-1:0]  wb_data;
    logic [DEST_W-1:0] wb_dest;
    logic              wb_err;
    logic              busy;

    int tests = 0;
    int fails = 0;
    int starts = 0;

    always #5 clk = ~clk;

    shift_issue_ctrl #(
        .WIDTH(WIDTH), .AMT_W(AMT_W), .DEST_W(DEST_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl(req_ctrl), .req_amt(req_amt),
        .req_data(req_data), .req_dest(req_dest),
        .sh_start(sh_start), .sh_ctrl(sh_ctrl),
        .sh_amt(sh_amt), .sh_data(sh_data),
        .sh_result(sh_result), .sh_done(sh_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_dest(wb_dest),
        .wb_err(wb_err), .busy(busy)
    );

    function automatic logic [7:0] ref_shift(input logic [1:0] c,
                                             input logic [2:0] a,
                                             input logic [7:0] d);
        logic [15:0] dd;
        int s;
        s = int'(a);
        dd = {d, d};
        case (c)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return dd[7:0] == 8'h00 ? 8'h00 : 8'(dd >> s);
        endcase
    endfunction

    // Shifter stub: done rises lat edges after start and stays high
    // (a stale level) until the next start; stale_hold keeps it high
    // through the first wait cycle of the next op.
    int          lat;
    logic        stale_hold;
    int          k;
    logic        running;
    logic [7:0]  pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_done   <= 1'b0;
            sh_result <= '0;
            k         <= 0;
            running   <= 1'b0;
            pend      <= '0;
        end else if (sh_start) begin
            k       <= 0;
            running <= 1'b1;
            sh_done <= stale_hold;
            pend    <= ref_shift(sh_ctrl, sh_amt, sh_data);
        end else if (running) begin
            k <= k + 1;
            if (lat != NEVER && k + 1 >= lat) begin
                sh_done   <= 1'b1;
                sh_result <= pend;
                running   <= 1'b0;
            end else begin
                sh_done <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && sh_start) starts++;
    end

    typedef struct {
        logic [1:0] ctrl;
        logic [2:0] amt;
        logic [7:0] data;
        logic [2:0] dest;
        int         lat;
        bit         stale;
        int         hold;
        logic [7:0] exp_data;
        bit         exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected completion from the rules: done is visible in wait cycle
    // lat+1 and must arrive by wait cycle TIMEOUT, else an error result.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        if (v.lat != NEVER && v.lat + 1 <= TIMEOUT) begin
            r.exp_data = ref_shift(v.ctrl, v.amt, v.data);
            r.exp_err  = 1'b0;
        end else begin
            r.exp_data = 8'h00;
            r.exp_err  = 1'b1;
        end
`ifdef SHIFT_ZERO_BYPASS_EN
        if (v.amt == 3'd0) begin
            r.exp_data = v.data;
            r.exp_err  = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic run_op(input vec_t v);
        int n;
        int nw;
        int exp_n;
        int exp_st;
        int s0;
        logic [7:0] d_seen;
        lat        = v.lat;
        stale_hold = v.stale;
        wb_ready   = 1'b0;
        req_valid  = 1'b1;
        req_ctrl   = v.ctrl;
        req_amt    = v.amt;
        req_data   = v.data;
        req_dest   = v.dest;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        s0 = starts;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        req_ctrl  = 2'($urandom);
        req_dest  = 3'($urandom);
        nw = (v.lat != NEVER && v.lat + 1 <= TIMEOUT) ? v.lat + 1 : TIMEOUT;
        exp_n  = 1 + nw;
        exp_st = 1;
`ifdef SHIFT_ZERO_BYPASS_EN
        if (v.amt == 3'd0) begin
            exp_n  = 0;
            exp_st = 0;
        end
`endif
        n = 0;
        while (!wb_valid && n < 400) begin
            wb_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        wb_ready = 1'b0;
        chk("latency", 32'(n), 32'(exp_n));
        chk("wb_data", 32'(wb_data), 32'(v.exp_data));
        chk("wb_err", 32'(wb_err), 32'(v.exp_err));
        chk("wb_dest", 32'(wb_dest), 32'(v.dest));
        chk("start_pulses", 32'(starts - s0), 32'(exp_st));
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        d_seen    = wb_data;
        req_valid = 1'b1;
        req_amt   = 3'd1;
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(wb_valid), 32'd1);
            chk("hold_data", 32'(wb_data), 32'(d_seen));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready  = 1'b0;
        req_valid = 1'b0;
        chk("release_valid", 32'(wb_valid), 32'd0);
        chk("release_ready", 32'(req_ready), 32'd1);
        chk("handover_no_accept", 32'(busy), 32'd0);
    endtask

    vec_t tbl[11];
    vec_t v;
    bit   seen_wb;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        tbl[0]  = '{2'b00, 3'd1, 8'hB3, 3'd5, 2,     1'b0, 0, 8'h66, 1'b0};
        tbl[1]  = '{2'b01, 3'd2, 8'hB3, 3'd1, 1,     1'b0, 4, 8'h2C, 1'b0};
        tbl[2]  = '{2'b10, 3'd3, 8'hB3, 3'd2, 3,     1'b0, 4, 8'hF6, 1'b0};
        tbl[3]  = '{2'b11, 3'd4, 8'hB3, 3'd3, 1,     1'b1, 0, 8'h3B, 1'b0};
        tbl[4]  = '{2'b11, 3'd1, 8'hB3, 3'd4, 4,     1'b1, 1, 8'hD9, 1'b0};
        tbl[5]  = '{2'b00, 3'd1, 8'hB3, 3'd6, NEVER, 1'b0, 2, 8'h00, 1'b1};
        tbl[6]  = '{2'b00, 3'd2, 8'h0F, 3'd7, 2,     1'b0, 0, 8'h3C, 1'b0};
        tbl[7]  = '{2'b01, 3'd1, 8'h80, 3'd0, 14,    1'b0, 0, 8'h40, 1'b0};
        tbl[8]  = '{2'b01, 3'd1, 8'h80, 3'd1, 15,    1'b0, 1, 8'h00, 1'b1};
        tbl[9]  = '{2'b00, 3'd0, 8'hA5, 3'd2, 2,     1'b0, 0, 8'hA5, 1'b0};
        tbl[10] = '{2'b10, 3'd7, 8'h80, 3'd5, 5,     1'b0, 0, 8'hFF, 1'b0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_ctrl   = '0;
        req_amt    = '0;
        req_data   = '0;
        req_dest   = '0;
        wb_ready   = 1'b0;
        lat        = 1;
        stale_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_sh_start", 32'(sh_start), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i]);
        end

        lat        = NEVER;
        stale_hold = 1'b0;
        req_valid  = 1'b1;
        req_ctrl   = 2'b01;
        req_amt    = 3'd2;
        req_data   = 8'hC3;
        req_dest   = 3'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_sh_data", 32'(sh_data), 32'd0);
        chk("mid_rst_sh_amt", 32'(sh_amt), 32'd0);
        chk("mid_rst_wb_data", 32'(wb_data), 32'd0);
        chk("mid_rst_wb_dest", 32'(wb_dest), 32'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        seen_wb = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (wb_valid || busy) seen_wb = 1'b1;
        end
        chk("mid_rst_no_wb", 32'(seen_wb), 32'd0);
        chk("mid_rst_ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            v.ctrl  = 2'($urandom);
            v.amt   = 3'($urandom);
            v.data  = 8'($urandom);
            v.dest  = 3'($urandom);
            v.lat   = ($urandom_range(0, 9) == 0) ? NEVER
                                                  : int'($urandom_range(1, 18));
            v.stale = 1'($urandom);
            v.hold  = int'($urandom_range(0, 3));
            v.exp_data = 8'h00;
            v.exp_err  = 1'b0;
            run_op(model(v));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
